id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  Decode->execute pipeline register; consumes the control-unit bundles (EX/MEM/WB, flush).
//  Latches one issued instruction per cycle and supports stall (hold) and kill (squash to bubble).
//  Handles two-word instructions: flush_in=1 marks the next fetched word as an immediate.
//  That immediate is captured and merged; the instruction issues as one EX slot.
// PARAMETERS
//  DATA_W      16  instruction word / register data / immediate width
//  REG_ADDR_W  3   register index width
//  EX_W        6   EX bundle: {ALUop[3:0], ALU_en, shamSel}
//  MEM_W       4   MEM bundle: {memRead, memWrite, memAddress, memData}
//  WB_W        3   WB bundle: {regWrite, WBsel[1:0]}
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           async active-low reset
//  valid_in     in   1           decode slot holds a fetched word
//  instr_in     in   DATA_W      raw fetched word (the immediate when in WAIT_IMM)
//  ex_sig_in    in   EX_W        control-unit EX bundle
//  mem_sig_in   in   MEM_W       control-unit MEM bundle
//  wb_sig_in    in   WB_W        control-unit WB bundle
//  flush_in     in   1           control unit: current opcode is two-word (LDM)
//  rs_data_in   in   DATA_W      source register value
//  rd_addr_in   in   REG_ADDR_W  destination register index
//  stall_in     in   1           hazard unit: hold all state and outputs
//  kill_in      in   1           squash: output bubble, drop pending two-word op
//  valid_out    out  1           EX slot holds a real instruction
//  ex_sig_out   out  EX_W        registered bundles / operands for EX
//  mem_sig_out  out  MEM_W
//  wb_sig_out   out  WB_W
//  rs_data_out  out  DATA_W
//  rd_addr_out  out  REG_ADDR_W
//  imm_out      out  DATA_W      merged immediate; 0 for one-word ops
//  imm_pending  out  1           combinational: state==WAIT_IMM (decoder must ignore its opcode)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=NORMAL; all outputs 0 (bubble); holding regs 0.
//  Bubble = valid_out 0, all bundles 0, imm_out 0.
//  Priority each edge: kill_in > stall_in > normal update.
//  kill_in=1: next outputs are a bubble; state returns to NORMAL; holding regs cleared. Kill overrides stall.
//  stall_in=1 (no kill): every register holds, including state and holding regs.
//  State NORMAL, valid_in=0: bubble.
//  State NORMAL, valid_in=1, flush_in=0: latch bundles/operands; imm_out=0; valid_out=1. Latency: 1 cycle.
//  State NORMAL, valid_in=1, flush_in=1:
//    copy bundles/rs/rd into holding regs; emit bubble; go to WAIT_IMM.
//  State WAIT_IMM, valid_in=0: bubble; stay.
//  State WAIT_IMM, valid_in=1: emit held bundles with imm_out=instr_in and valid_out=1; go to NORMAL.
//    Ignore flush_in and the live bundles (the word is data, not an opcode).
//  WB sanitise: if MEM memWrite bit (bit 2) is set, wb_sig_out is forced to 0, because the
//    control unit leaves WB undefined for stores.
//  No arithmetic; all widths pass through unchanged. Reset mid-WAIT_IMM drops the pending op silently.
// STRUCTURE
//  Shared package: EX_W/MEM_W/WB_W, bundle bit positions (MEM_WRITE_BIT=2), BUBBLE constants, state enum {NORMAL, WAIT_IMM}.
//  One flat module; no sub-module: two-state FSM plus holding regs plus output regs.
// TESTING
//  1. ADD valid_in=1, ex=6'b001010, wb=3'b101 -> next cycle valid_out=1, ex_sig_out=6'b001010, imm_out=0.
//  2. LDM (mem=4'b1000, wb=3'b110, flush_in=1), then word 16'hBEEF -> cycle1 bubble with imm_pending=1;
//     cycle2 valid_out=1, mem=4'b1000, imm_out=16'hBEEF.
//  3. LDM, valid_in=0 for 3 cycles, then 16'h0042 -> 3 bubbles with imm_pending=1, then merged op with imm_out=16'h0042.
//  4. stall_in=1 for 2 cycles during WAIT_IMM -> outputs and state frozen; imm arrives after stall -> merged correctly.
//  5. kill_in=1 together with stall_in=1 in WAIT_IMM -> bubble; NORMAL; next ADD issues normally.
//  6. STD mem=4'b0110, wb=3'b111 -> wb_sig_out=3'b000; assert rst_n=0 mid-LDM -> all outputs 0 at once.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths, bundle layout, bubble constants and FSM state type for the
// decode->execute pipeline register.
package id_ex_stage_reg_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned EX_W       = 6;
    localparam int unsigned MEM_W      = 4;
    localparam int unsigned WB_W       = 3;

    // MEM bundle = {memRead, memWrite, memAddress, memData}
    localparam int unsigned MEM_READ_BIT  = 3;
    localparam int unsigned MEM_WRITE_BIT = 2;
    // WB bundle = {regWrite, WBsel[1:0]}
    localparam int unsigned WB_REGWRITE_BIT = 2;

    typedef enum logic {
        NORMAL   = 1'b0,
        WAIT_IMM = 1'b1
    } stage_state_e;

    // Everything that travels from decode to execute alongside one instruction.
    typedef struct packed {
        logic [EX_W-1:0]       ex;
        logic [MEM_W-1:0]      mem;
        logic [WB_W-1:0]       wb;
        logic [DATA_W-1:0]     rs_data;
        logic [REG_ADDR_W-1:0] rd_addr;
    } issue_bundle_t;

    localparam issue_bundle_t     BUBBLE_BUNDLE = '0;
    localparam logic [DATA_W-1:0] BUBBLE_IMM    = '0;

    // Stores leave WB undefined in the control unit, so force it to zero.
    function automatic issue_bundle_t sanitize_wb(input issue_bundle_t b);
        issue_bundle_t r;
        r = b;
        if (b.mem[MEM_WRITE_BIT]) begin
            r.wb = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/kill and two-word (LDM) immediate merge:
// the opcode word parks in holding regs until the following word arrives.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     instr_in,
    input  logic [EX_W-1:0]       ex_sig_in,
    input  logic [MEM_W-1:0]      mem_sig_in,
    input  logic [WB_W-1:0]       wb_sig_in,
    input  logic                  flush_in,
    input  logic [DATA_W-1:0]     rs_data_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  stall_in,
    input  logic                  kill_in,
    output logic                  valid_out,
    output logic [EX_W-1:0]       ex_sig_out,
    output logic [MEM_W-1:0]      mem_sig_out,
    output logic [WB_W-1:0]       wb_sig_out,
    output logic [DATA_W-1:0]     rs_data_out,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [DATA_W-1:0]     imm_out,
    output logic                  imm_pending
);

    stage_state_e      state_q, state_d;
    issue_bundle_t     hold_q,  hold_d;
    issue_bundle_t     out_q,   out_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    issue_bundle_t     live_c;

    assign live_c = {ex_sig_in, mem_sig_in, wb_sig_in, rs_data_in, rd_addr_in};

    // Next-state and next-output selection; kill beats stall beats normal flow.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        out_d   = out_q;
        valid_d = valid_q;
        imm_d   = imm_q;

        if (kill_in) begin
            state_d = NORMAL;
            hold_d  = BUBBLE_BUNDLE;
            out_d   = BUBBLE_BUNDLE;
            valid_d = 1'b0;
            imm_d   = BUBBLE_IMM;
        end else if (!stall_in) begin
            unique case (state_q)
                NORMAL: begin
                    out_d   = BUBBLE_BUNDLE;
                    valid_d = 1'b0;
                    imm_d   = BUBBLE_IMM;
                    if (valid_in && !flush_in) begin
                        out_d   = sanitize_wb(live_c);
                        valid_d = 1'b1;
                    end else if (valid_in && flush_in) begin
                        hold_d  = live_c;
                        state_d = WAIT_IMM;
                    end
                end
                WAIT_IMM: begin
                    out_d   = BUBBLE_BUNDLE;
                    valid_d = 1'b0;
                    imm_d   = BUBBLE_IMM;
                    // This word is the immediate; its decode is meaningless.
                    if (valid_in) begin
                        out_d   = sanitize_wb(hold_q);
                        valid_d = 1'b1;
                        imm_d   = instr_in;
                        hold_d  = BUBBLE_BUNDLE;
                        state_d = NORMAL;
                    end
                end
                default: begin
                    state_d = NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            hold_q  <= BUBBLE_BUNDLE;
            out_q   <= BUBBLE_BUNDLE;
            valid_q <= 1'b0;
            imm_q   <= BUBBLE_IMM;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
        end
    end

    assign valid_out   = valid_q;
    assign ex_sig_out  = out_q.ex;
    assign mem_sig_out = out_q.mem;
    assign wb_sig_out  = out_q.wb;
    assign rs_data_out = out_q.rs_data;
    assign rd_addr_out = out_q.rd_addr;
    assign imm_out     = imm_q;
    assign imm_pending = (state_q == WAIT_IMM);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: each driven cycle pushes its expected
// post-edge outputs; the scenario task pops and compares after the edge.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] instr_in;
    logic [5:0]  ex_sig_in;
    logic [3:0]  mem_sig_in;
    logic [2:0]  wb_sig_in;
    logic        flush_in;
    logic [15:0] rs_data_in;
    logic [2:0]  rd_addr_in;
    logic        stall_in;
    logic        kill_in;
    logic        valid_out;
    logic [5:0]  ex_sig_out;
    logic [3:0]  mem_sig_out;
    logic [2:0]  wb_sig_out;
    logic [15:0] rs_data_out;
    logic [2:0]  rd_addr_out;
    logic [15:0] imm_out;
    logic        imm_pending;

    typedef struct packed {
        logic        v;
        logic [15:0] instr;
        logic [5:0]  ex;
        logic [3:0]  mem;
        logic [2:0]  wb;
        logic        fl;
        logic [15:0] rs;
        logic [2:0]  rd;
        logic        st;
        logic        kl;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ex;
        logic [3:0]  mem;
        logic [2:0]  wb;
        logic [15:0] rs;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic        pend;
    } obs_t;

    obs_t obs;
    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    assign obs = {valid_out, ex_sig_out, mem_sig_out, wb_sig_out,
                  rs_data_out, rd_addr_out, imm_out, imm_pending};

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_in(instr_in),
        .ex_sig_in(ex_sig_in), .mem_sig_in(mem_sig_in), .wb_sig_in(wb_sig_in),
        .flush_in(flush_in), .rs_data_in(rs_data_in), .rd_addr_in(rd_addr_in),
        .stall_in(stall_in), .kill_in(kill_in), .valid_out(valid_out),
        .ex_sig_out(ex_sig_out), .mem_sig_out(mem_sig_out), .wb_sig_out(wb_sig_out),
        .rs_data_out(rs_data_out), .rd_addr_out(rd_addr_out), .imm_out(imm_out),
        .imm_pending(imm_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t S(input logic v, input logic [15:0] instr, input logic [5:0] ex,
                                input logic [3:0] mem, input logic [2:0] wb, input logic fl,
                                input logic [15:0] rs, input logic [2:0] rd,
                                input logic st, input logic kl);
        stim_t s;
        s = {v, instr, ex, mem, wb, fl, rs, rd, st, kl};
        return s;
    endfunction

    function automatic obs_t E(input logic valid, input logic [5:0] ex, input logic [3:0] mem,
                               input logic [2:0] wb, input logic [15:0] rs, input logic [2:0] rd,
                               input logic [15:0] imm, input logic pend);
        obs_t e;
        e = {valid, ex, mem, wb, rs, rd, imm, pend};
        return e;
    endfunction

    function automatic obs_t BUB(input logic pend);
        return E(1'b0, 6'd0, 4'd0, 3'd0, 16'd0, 3'd0, 16'd0, pend);
    endfunction

    function automatic stim_t IDLE();
        return S(1'b0, 16'h0, 6'd0, 4'd0, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    endfunction

    // Drive one cycle of stimulus, record its expectation, advance past the edge.
    task automatic apply(input stim_t s, input obs_t e);
        valid_in   = s.v;
        instr_in   = s.instr;
        ex_sig_in  = s.ex;
        mem_sig_in = s.mem;
        wb_sig_in  = s.wb;
        flush_in   = s.fl;
        rs_data_in = s.rs;
        rd_addr_in = s.rd;
        stall_in   = s.st;
        kill_in    = s.kl;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        valid_in = 1'b0; instr_in = '0; ex_sig_in = '0; mem_sig_in = '0; wb_sig_in = '0;
        flush_in = 1'b0; rs_data_in = '0; rd_addr_in = '0; stall_in = 1'b0; kill_in = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (obs !== BUB(1'b0)) begin
            errors++;
            $display("FAIL reset got %h exp %h", obs, BUB(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        sq.push_back(S(1, 16'h1A00, 6'b001010, 4'b0000, 3'b101, 0, 16'h1234, 3'd5, 0, 0));
        eq.push_back(E(1, 6'b001010, 4'b0000, 3'b101, 16'h1234, 3'd5, 16'h0, 0));
        sq.push_back(IDLE());
        eq.push_back(BUB(0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL add[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL add[%0d] got %h exp %h", i, obs, e);
                end
            end
        end
    endtask

    task automatic test_ldm();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        sq.push_back(S(1, 16'hC000, 6'b000011, 4'b1000, 3'b110, 1, 16'h00AA, 3'd3, 0, 0));
        eq.push_back(BUB(1));
        sq.push_back(S(1, 16'hBEEF, 6'b111111, 4'b0100, 3'b111, 1, 16'hFFFF, 3'd7, 0, 0));
        eq.push_back(E(1, 6'b000011, 4'b1000, 3'b110, 16'h00AA, 3'd3, 16'hBEEF, 0));
        sq.push_back(IDLE());
        eq.push_back(BUB(0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL ldm[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL ldm[%0d] got %h exp %h", i, obs, e);
                end
            end
        end
    endtask

    task automatic test_ldm_gap();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        sq.push_back(S(1, 16'hC100, 6'b000100, 4'b1000, 3'b110, 1, 16'h0011, 3'd2, 0, 0));
        eq.push_back(BUB(1));
        for (int k = 0; k < 3; k++) begin
            sq.push_back(S(0, 16'h1111, 6'b110011, 4'b0110, 3'b011, 1, 16'h7777, 3'd6, 0, 0));
            eq.push_back(BUB(1));
        end
        sq.push_back(S(1, 16'h0042, 6'b101010, 4'b0001, 3'b001, 0, 16'h5555, 3'd1, 0, 0));
        eq.push_back(E(1, 6'b000100, 4'b1000, 3'b110, 16'h0011, 3'd2, 16'h0042, 0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL ldm_gap[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL ldm_gap[%0d] got %h exp %h", i, obs, e);
                end
            end
        end
    endtask

    task automatic test_stall();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        sq.push_back(S(1, 16'h0000, 6'b000110, 4'b0000, 3'b100, 0, 16'h0A0A, 3'd1, 0, 0));
        eq.push_back(E(1, 6'b000110, 4'b0000, 3'b100, 16'h0A0A, 3'd1, 16'h0, 0));
        sq.push_back(S(1, 16'h0000, 6'b011001, 4'b1000, 3'b010, 0, 16'hF0F0, 3'd6, 1, 0));
        eq.push_back(E(1, 6'b000110, 4'b0000, 3'b100, 16'h0A0A, 3'd1, 16'h0, 0));
        sq.push_back(S(1, 16'hC200, 6'b001000, 4'b1000, 3'b110, 1, 16'h00BB, 3'd4, 0, 0));
        eq.push_back(BUB(1));
        for (int k = 0; k < 2; k++) begin
            sq.push_back(S(1, 16'hDEAD, 6'b111000, 4'b0010, 3'b001, 0, 16'h1357, 3'd0, 1, 0));
            eq.push_back(BUB(1));
        end
        sq.push_back(S(1, 16'h5A5A, 6'b000000, 4'b0000, 3'b000, 0, 16'h0000, 3'd0, 0, 0));
        eq.push_back(E(1, 6'b001000, 4'b1000, 3'b110, 16'h00BB, 3'd4, 16'h5A5A, 0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stall[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL stall[%0d] got %h exp %h", i, obs, e);
                end
            end
        end
    endtask

    task automatic test_kill();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        sq.push_back(S(1, 16'hC300, 6'b000101, 4'b1000, 3'b110, 1, 16'h00CC, 3'd6, 0, 0));
        eq.push_back(BUB(1));
        sq.push_back(S(1, 16'h7777, 6'b000000, 4'b0000, 3'b000, 0, 16'h0000, 3'd0, 1, 1));
        eq.push_back(BUB(0));
        sq.push_back(S(1, 16'h9999, 6'b001010, 4'b0000, 3'b101, 0, 16'h0102, 3'd5, 0, 0));
        eq.push_back(E(1, 6'b001010, 4'b0000, 3'b101, 16'h0102, 3'd5, 16'h0, 0));
        sq.push_back(S(1, 16'h0000, 6'b010001, 4'b0000, 3'b100, 0, 16'h0200, 3'd1, 0, 1));
        eq.push_back(BUB(0));
        sq.push_back(S(1, 16'h3333, 6'b010001, 4'b0000, 3'b100, 0, 16'h0200, 3'd1, 0, 0));
        eq.push_back(E(1, 6'b010001, 4'b0000, 3'b100, 16'h0200, 3'd1, 16'h0, 0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL kill[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL kill[%0d] got %h exp %h", i, obs, e);
                end
            end
        end
    endtask

    task automatic test_store();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        sq.push_back(S(1, 16'h0000, 6'b000010, 4'b0110, 3'b111, 0, 16'h0F0F, 3'd2, 0, 0));
        eq.push_back(E(1, 6'b000010, 4'b0110, 3'b000, 16'h0F0F, 3'd2, 16'h0, 0));
        sq.push_back(S(1, 16'h0000, 6'b100001, 4'b1011, 3'b011, 0, 16'h4444, 3'd7, 0, 0));
        eq.push_back(E(1, 6'b100001, 4'b1011, 3'b011, 16'h4444, 3'd7, 16'h0, 0));
        sq.push_back(S(1, 16'hC400, 6'b000111, 4'b0100, 3'b111, 1, 16'h0066, 3'd3, 0, 0));
        eq.push_back(BUB(1));
        sq.push_back(S(1, 16'h1234, 6'b000000, 4'b0000, 3'b111, 0, 16'h0000, 3'd0, 0, 0));
        eq.push_back(E(1, 6'b000111, 4'b0100, 3'b000, 16'h0066, 3'd3, 16'h1234, 0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL store[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL store[%0d] got %h exp %h", i, obs, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        // First establish a non-bubble output so the reset has something to clear.
        apply(S(1, 16'h0000, 6'b011011, 4'b0001, 3'b101, 0, 16'h8888, 3'd4, 0, 0),
              E(1, 6'b011011, 4'b0001, 3'b101, 16'h8888, 3'd4, 16'h0, 0));
        checks++;
        e = sb.pop_front();
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_mid_pre got %h exp %h", obs, e);
        end
        apply(S(1, 16'hC500, 6'b001100, 4'b1000, 3'b110, 1, 16'h00DD, 3'd5, 0, 0), BUB(1));
        checks++;
        e = sb.pop_front();
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_mid_ldm got %h exp %h", obs, e);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs !== BUB(0)) begin
            errors++;
            $display("FAIL rst_mid_async got %h exp %h", obs, BUB(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(S(1, 16'hABCD, 6'b000001, 4'b0000, 3'b100, 0, 16'h0001, 3'd1, 0, 0),
              E(1, 6'b000001, 4'b0000, 3'b100, 16'h0001, 3'd1, 16'h0, 0));
        checks++;
        e = sb.pop_front();
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_mid_after got %h exp %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        stim_t sq[$];
        obs_t  eq[$];
        obs_t  e;
        sq.push_back(S(1, 16'h0000, 6'b001001, 4'b0000, 3'b100, 0, 16'h1111, 3'd1, 0, 0));
        eq.push_back(E(1, 6'b001001, 4'b0000, 3'b100, 16'h1111, 3'd1, 16'h0, 0));
        sq.push_back(S(1, 16'h0000, 6'b010010, 4'b0000, 3'b101, 0, 16'h2222, 3'd2, 0, 0));
        eq.push_back(E(1, 6'b010010, 4'b0000, 3'b101, 16'h2222, 3'd2, 16'h0, 0));
        sq.push_back(S(1, 16'hC600, 6'b011100, 4'b1000, 3'b110, 1, 16'h3333, 3'd3, 0, 0));
        eq.push_back(BUB(1));
        sq.push_back(S(1, 16'hCAFE, 6'b111111, 4'b1111, 3'b111, 1, 16'hFFFF, 3'd7, 0, 0));
        eq.push_back(E(1, 6'b011100, 4'b1000, 3'b110, 16'h3333, 3'd3, 16'hCAFE, 0));
        sq.push_back(S(1, 16'h0000, 6'b100100, 4'b0000, 3'b100, 0, 16'h4444, 3'd4, 0, 0));
        eq.push_back(E(1, 6'b100100, 4'b0000, 3'b100, 16'h4444, 3'd4, 16'h0, 0));
        for (int i = 0; i < sq.size(); i++) begin
            apply(sq[i], eq[i]);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b[%0d] scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL b2b[%0d] got %h exp %h", i, obs, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldm();
        test_ldm_gap();
        test_stall();
        test_kill();
        test_store();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
